// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pattern mode encoding and colour helpers.
// Used by the pattern generator and the downstream VGA timing stage.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_TOTAL_DEF  = 800;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_TOTAL_DEF  = 525;
    localparam int BOX_SIZE_DEF = 32;
    localparam int BAR_WIDTH    = 80;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_GRAD  = 2'd2,
        MODE_BOX   = 2'd3
    } mode_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};
    localparam rgb_t RGB_WHITE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
    localparam rgb_t RGB_BLUE  = '{r: 8'h00, g: 8'h00, b: 8'hFF};

    // Compare chain instead of a divider: bar index is just x/80 for x < 640.
    function automatic logic [2:0] bar_index(input logic [9:0] x);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (x >= 10'(i * BAR_WIDTH)) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
            3'd1:    c = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
            3'd2:    c = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
            3'd3:    c = '{r: 8'h00, g: 8'hFF, b: 8'h00};
            3'd4:    c = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
            3'd5:    c = '{r: 8'hFF, g: 8'h00, b: 8'h00};
            3'd6:    c = '{r: 8'h00, g: 8'h00, b: 8'hFF};
            default: c = '{r: 8'h00, g: 8'h00, b: 8'h00};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: moves 2 px per axis on each update strobe, reversing at the edges.
// Registered outputs, 1 clk after update; no backpressure, update is a single-clk strobe.
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int BOX_SIZE = BOX_SIZE_DEF
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       update,
    output logic [9:0] bx,
    output logic [9:0] by
);

    localparam logic [9:0] BX_MAX = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0] BY_MAX = 10'(V_ACTIVE - BOX_SIZE);

    logic dx;
    logic dy;

    // Returns {next_dir, next_pos}; the forward sum is 11 bits so it cannot wrap.
    function automatic logic [10:0] step(input logic [9:0] pos, input logic dir,
                                         input logic [9:0] lim);
        logic [10:0] fwd;
        logic [10:0] nxt;
        fwd = {1'b0, pos} + 11'd2;
        if (dir) begin
            if (fwd > {1'b0, lim}) begin
                nxt = {1'b0, lim};
            end else begin
                nxt = {1'b1, fwd[9:0]};
            end
        end else begin
            if (pos < 10'd2) begin
                nxt = {1'b1, 10'd0};
            end else begin
                nxt = {1'b0, pos - 10'd2};
            end
        end
        return nxt;
    endfunction

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bx <= 10'd0;
            by <= 10'd0;
            dx <= 1'b1;
            dy <= 1'b1;
        end else if (update) begin
            {dx, bx} <= step(bx, dx, BX_MAX);
            {dy, by} <= step(by, dy, BY_MAX);
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern source: pixel counters, per-frame mode latch and four colour patterns.
// Colour and coordinates registered 1 clk after each pix_ce edge; no backpressure.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int BOX_SIZE = BOX_SIZE_DEF
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       pix_ce,
    input  logic [1:0] mode_sel,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       frame_start,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y
);

    localparam logic [9:0]  X_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  X_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0]  Y_ACT  = 10'(V_ACTIVE);
    localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);

    logic [9:0] x;
    logic [9:0] y;
    mode_t      mode_q;
    logic [9:0] bx;
    logic [9:0] by;
    logic       x_wrap;
    logic       frame_wrap;
    logic       box_update;
    logic       active;
    logic       in_box;
    rgb_t       pattern;
    rgb_t       colour;

    assign x_wrap     = (x == X_LAST);
    assign frame_wrap = x_wrap && (y == Y_LAST);
    // Box moves during vertical blanking so a frame never shows a torn box.
    assign box_update = pix_ce && (x == 10'd0) && (y == Y_ACT);
    assign active     = (x < X_ACT) && (y < Y_ACT);

    assign in_box = ({1'b0, x} >= {1'b0, bx}) && ({1'b0, x} < {1'b0, bx} + BOX_W) &&
                    ({1'b0, y} >= {1'b0, by}) && ({1'b0, y} < {1'b0, by} + BOX_W);

    vga_box_mover #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BOX_SIZE (BOX_SIZE)
    ) u_box (
        .clk    (clk),
        .arst_n (arst_n),
        .update (box_update),
        .bx     (bx),
        .by     (by)
    );

    always_comb begin
        pattern = RGB_BLACK;
        case (mode_q)
            MODE_BARS:  pattern = bar_colour(bar_index(x));
            MODE_CHECK: pattern = (x[5] ^ y[5]) ? RGB_WHITE : RGB_BLACK;
            MODE_GRAD: begin
                pattern.r = x[9:2];
                pattern.g = y[8:1];
                pattern.b = 8'hFF - x[9:2];
            end
            MODE_BOX:   pattern = in_box ? RGB_WHITE : RGB_BLUE;
            default:    pattern = RGB_BLACK;
        endcase
        colour = active ? pattern : RGB_BLACK;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            x           <= 10'd0;
            y           <= 10'd0;
            mode_q      <= MODE_BARS;
            red         <= 8'd0;
            green       <= 8'd0;
            blue        <= 8'd0;
            pix_x       <= 10'd0;
            pix_y       <= 10'd0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_ce) begin
                red   <= colour.r;
                green <= colour.g;
                blue  <= colour.b;
                pix_x <= x;
                pix_y <= y;
                if (x_wrap) begin
                    x <= 10'd0;
                    if (frame_wrap) begin
                        y           <= 10'd0;
                        mode_q      <= mode_t'(mode_sel);
                        frame_start <= 1'b1;
                    end else begin
                        y <= y + 10'd1;
                    end
                end else begin
                    x <= x + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench: a wide/short instance for counters and patterns at half pixel rate,
// and a small instance at full pixel rate for bouncing-box motion and rendering.
module tb_vga_pattern_gen;

    localparam int HT     = 648;
    localparam int VT     = 7;
    localparam int FRAME  = HT * VT;
    localparam int BHT    = 44;
    localparam int BVA    = 20;
    localparam int BVT    = 22;
    localparam int BFRAME = BHT * BVT;

    typedef struct {
        int          x;
        int          y;
        logic [23:0] rgb;
    } pix_vec_t;

    typedef struct {
        int   m;
        int   bx;
        int   by;
        logic dx;
        logic dy;
    } box_vec_t;

    logic       clk;
    logic       arst_n;
    logic       pix_ce;
    logic [1:0] mode_sel;
    logic [7:0] red, green, blue;
    logic       frame_start;
    logic [9:0] pix_x, pix_y;

    logic       arst_n_b;
    logic       pix_ce_b;
    logic [1:0] mode_sel_b;
    logic [7:0] red_b, green_b, blue_b;
    logic       frame_start_b;
    logic [9:0] pix_x_b, pix_y_b;

    int checks;
    int errors;
    int cur;
    int eb;

    vga_pattern_gen #(
        .H_ACTIVE (640), .H_TOTAL (HT), .V_ACTIVE (6), .V_TOTAL (VT), .BOX_SIZE (4)
    ) dut (
        .clk (clk), .arst_n (arst_n), .pix_ce (pix_ce), .mode_sel (mode_sel),
        .red (red), .green (green), .blue (blue), .frame_start (frame_start),
        .pix_x (pix_x), .pix_y (pix_y)
    );

    vga_pattern_gen #(
        .H_ACTIVE (40), .H_TOTAL (BHT), .V_ACTIVE (BVA), .V_TOTAL (BVT), .BOX_SIZE (8)
    ) dut_b (
        .clk (clk), .arst_n (arst_n_b), .pix_ce (pix_ce_b), .mode_sel (mode_sel_b),
        .red (red_b), .green (green_b), .blue (blue_b), .frame_start (frame_start_b),
        .pix_x (pix_x_b), .pix_y (pix_y_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 25 MHz pixel strobe from the 50 MHz clock: high on every second clk.
    initial begin
        pix_ce = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pix_ce = ~pix_ce;
        end
    end

    task automatic advance1();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(posedge clk);
            if (pix_ce) seen = 1'b1;
        end
        #1;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL advance: no pix_ce strobe within 4 clk");
        end
        cur = (cur + 1) % FRAME;
    endtask

    task automatic goto_pix(input int tx, input int ty);
        int n;
        n = (ty * HT + tx - cur + FRAME) % FRAME;
        repeat (n) advance1();
    endtask

    task automatic check_table(input string name, input pix_vec_t tbl[]);
        foreach (tbl[i]) begin
            goto_pix(tbl[i].x, tbl[i].y);
            checks++;
            if ({red, green, blue} !== tbl[i].rgb || pix_x !== 10'(tbl[i].x) ||
                pix_y !== 10'(tbl[i].y)) begin
                errors++;
                $display("FAIL %s(%0d,%0d): got rgb=%h at (%0d,%0d), expected rgb=%h",
                         name, tbl[i].x, tbl[i].y, {red, green, blue}, pix_x, pix_y, tbl[i].rgb);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({red, green, blue, pix_x, pix_y, frame_start} !== 45'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rgb=%h xy=(%0d,%0d) fs=%b, expected all zero",
                     {red, green, blue}, pix_x, pix_y, frame_start);
        end
        checks++;
        if ({dut.u_box.bx, dut.u_box.by, dut.u_box.dx, dut.u_box.dy, dut.mode_q} !==
            {10'd0, 10'd0, 1'b1, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL reset_state: got bx=%0d by=%0d dx=%b dy=%b mode=%0d, expected 0 0 1 1 0",
                     dut.u_box.bx, dut.u_box.by, dut.u_box.dx, dut.u_box.dy, dut.mode_q);
        end
        arst_n = 1'b1;
        cur = FRAME - 1;
        advance1();
        // mode_sel is 1 but is not latched until the first frame wrap, so bars show.
        checks++;
        if ({red, green, blue} !== 24'hFFFFFF || pix_x !== 10'd0 || pix_y !== 10'd0 ||
            frame_start !== 1'b0) begin
            errors++;
            $display("FAIL first_pixel: got rgb=%h (%0d,%0d) fs=%b, expected FFFFFF (0,0) fs=0",
                     {red, green, blue}, pix_x, pix_y, frame_start);
        end
        mode_sel = 2'd0;
    endtask

    task automatic test_frame_count();
        int cnt;
        cnt = 1;
        for (int i = 0; i < FRAME + 16; i++) begin
            advance1();
            cnt++;
            if (frame_start) break;
        end
        checks++;
        if (cnt !== FRAME || pix_x !== 10'(HT - 1) || pix_y !== 10'(VT - 1)) begin
            errors++;
            $display("FAIL first_frame_len: got %0d strobes ending at (%0d,%0d), expected %0d at (%0d,%0d)",
                     cnt, pix_x, pix_y, FRAME, HT - 1, VT - 1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL frame_start_width: got %b one clk after pulse, expected 0", frame_start);
        end
        cnt = 0;
        for (int i = 0; i < FRAME + 16; i++) begin
            advance1();
            cnt++;
            if (frame_start) break;
        end
        checks++;
        if (cnt !== FRAME) begin
            errors++;
            $display("FAIL frame_period: got %0d strobes between pulses, expected %0d", cnt, FRAME);
        end
    endtask

    task automatic test_bars();
        pix_vec_t tbl[];
        tbl = '{'{85, 2, 24'hFFFF00}, '{200, 2, 24'h00FFFF}, '{400, 2, 24'hFF0000},
                '{480, 2, 24'h0000FF}, '{639, 2, 24'h000000}, '{640, 2, 24'h000000},
                '{100, 6, 24'h000000}};
        check_table("bars", tbl);
        mode_sel = 2'd1;
    endtask

    task automatic test_checker();
        pix_vec_t tbl[];
        pix_vec_t tbl2[];
        tbl  = '{'{31, 1, 24'h000000}, '{32, 1, 24'hFFFFFF}, '{0, 4, 24'h000000}};
        check_table("checker", tbl);
        // Request gradient mid-frame; the checkerboard must persist to frame end.
        mode_sel = 2'd2;
        tbl2 = '{'{64, 5, 24'h000000}, '{96, 5, 24'hFFFFFF}};
        check_table("checker_hold", tbl2);
    endtask

    task automatic test_gradient();
        pix_vec_t tbl[];
        tbl = '{'{8, 2, 24'h0201FD}, '{636, 4, 24'h9F0260}, '{300, 5, 24'h4B02B4}};
        check_table("gradient", tbl);
    endtask

    task automatic test_reset_mid();
        arst_n = 1'b0;
        #1;
        checks++;
        if ({red, green, blue, pix_x, pix_y, frame_start} !== 45'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got rgb=%h xy=(%0d,%0d) fs=%b, expected all zero",
                     {red, green, blue}, pix_x, pix_y, frame_start);
        end
        checks++;
        if ({dut.u_box.bx, dut.u_box.by, dut.u_box.dx, dut.u_box.dy, dut.mode_q} !==
            {10'd0, 10'd0, 1'b1, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL midreset_state: got bx=%0d by=%0d dx=%b dy=%b mode=%0d, expected 0 0 1 1 0",
                     dut.u_box.bx, dut.u_box.by, dut.u_box.dx, dut.u_box.dy, dut.mode_q);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({red, green, blue, pix_x, pix_y} !== 44'd0) begin
            errors++;
            $display("FAIL midreset_hold: got rgb=%h xy=(%0d,%0d) with strobes in reset, expected zero",
                     {red, green, blue}, pix_x, pix_y);
        end
        arst_n = 1'b1;
        cur = FRAME - 1;
        advance1();
        checks++;
        if ({red, green, blue} !== 24'hFFFFFF || pix_x !== 10'd0 || pix_y !== 10'd0 ||
            frame_start !== 1'b0) begin
            errors++;
            $display("FAIL midreset_restart: got rgb=%h (%0d,%0d) fs=%b, expected FFFFFF (0,0) fs=0",
                     {red, green, blue}, pix_x, pix_y, frame_start);
        end
    endtask

    task automatic box_edge(input int target);
        repeat (target - eb) @(posedge clk);
        eb = target;
        #1;
    endtask

    task automatic test_box();
        box_vec_t st[];
        pix_vec_t px[];
        int       e;
        st = '{'{0, 0, 0, 1'b1, 1'b1}, '{1, 2, 2, 1'b1, 1'b1}, '{7, 14, 12, 1'b1, 1'b0},
               '{14, 28, 0, 1'b1, 1'b1}, '{17, 32, 6, 1'b0, 1'b1}, '{18, 30, 8, 1'b0, 1'b1}};
        px = '{'{29, 8, 24'h0000FF}, '{30, 8, 24'hFFFFFF}, '{40, 8, 24'h000000},
               '{37, 15, 24'hFFFFFF}, '{38, 15, 24'h0000FF}, '{30, 16, 24'h0000FF}};
        @(posedge clk);
        #1;
        arst_n_b = 1'b1;
        eb = 0;
        foreach (st[i]) begin
            // Update m lands on the strobe for pixel (0,BVA) of frame m; m=0 is the clk before.
            if (st[i].m == 0) e = BVA * BHT;
            else              e = BFRAME * (st[i].m - 1) + BVA * BHT + 1;
            box_edge(e);
            checks++;
            if (dut_b.u_box.bx !== 10'(st[i].bx) || dut_b.u_box.by !== 10'(st[i].by) ||
                dut_b.u_box.dx !== st[i].dx || dut_b.u_box.dy !== st[i].dy) begin
                errors++;
                $display("FAIL box_update%0d: got bx=%0d by=%0d dx=%b dy=%b, expected %0d %0d %b %b",
                         st[i].m, dut_b.u_box.bx, dut_b.u_box.by, dut_b.u_box.dx, dut_b.u_box.dy,
                         st[i].bx, st[i].by, st[i].dx, st[i].dy);
            end
        end
        foreach (px[i]) begin
            box_edge(BFRAME * 18 + px[i].y * BHT + px[i].x + 1);
            checks++;
            if ({red_b, green_b, blue_b} !== px[i].rgb || pix_x_b !== 10'(px[i].x) ||
                pix_y_b !== 10'(px[i].y)) begin
                errors++;
                $display("FAIL box_pix(%0d,%0d): got rgb=%h at (%0d,%0d), expected rgb=%h",
                         px[i].x, px[i].y, {red_b, green_b, blue_b}, pix_x_b, pix_y_b, px[i].rgb);
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cur        = 0;
        eb         = 0;
        mode_sel   = 2'd1;
        mode_sel_b = 2'd3;
        pix_ce_b   = 1'b1;
        arst_n     = 1'b1;
        arst_n_b   = 1'b1;
        #2;
        arst_n     = 1'b0;
        arst_n_b   = 1'b0;
        test_reset();
        test_frame_count();
        test_bars();
        test_checker();
        test_gradient();
        test_reset_mid();
        test_box();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
